// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage iterative multiply/divide unit.
// Operation codes follow the RV32M funct3 ordering.
package ex_muldiv_pkg;

    localparam int unsigned MdXlen = 32;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdCalc = 2'd1,
        MdDone = 2'd2
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op inside {MdDiv, MdDivu, MdRem, MdRemu};
    endfunction

    function automatic logic op_is_rem(md_op_e op);
        return op inside {MdRem, MdRemu};
    endfunction

    function automatic logic op_a_signed(md_op_e op);
        return op inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem};
    endfunction

    function automatic logic op_b_signed(md_op_e op);
        return op inside {MdMul, MdMulh, MdDiv, MdRem};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side handshake between the EX stage and the multiply/divide unit.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic                start;
    md_op_e              op;
    logic [MdXlen-1:0]   in_0;
    logic [MdXlen-1:0]   in_1;
    logic                flush;
    logic                stall_req;
    logic                busy;
    logic                done;
    logic [MdXlen-1:0]   out;

    modport master (
        output start, op, in_0, in_1, flush,
        input  stall_req, busy, done, out
    );

    modport slave (
        input  start, op, in_0, in_1, flush,
        output stall_req, busy, done, out
    );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on magnitudes,
// with sign fix-up folded into the DONE-entry edge.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MdXlen
) (
    input logic        clk_i,
    input logic        reset_i,
    ex_muldiv_if.slave md
);

    localparam int unsigned CntW = $clog2(XLEN);

    md_state_e             state_q;
    logic [CntW-1:0]       cnt_q;
    md_op_e                op_q;
    logic                  neg_q;
    logic                  nega_q;
    logic [XLEN-1:0]       d_q;
    logic [2*XLEN-1:0]     acc_q;
    logic                  busy_q;
    logic                  done_q;
    logic [XLEN-1:0]       out_q;

    logic                  neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]       a_mag, b_mag, fast_res;

    always_comb begin
        neg_a    = op_a_signed(md.op) & md.in_0[XLEN-1];
        neg_b    = op_b_signed(md.op) & md.in_1[XLEN-1];
        a_mag    = neg_a ? -md.in_0 : md.in_0;
        b_mag    = neg_b ? -md.in_1 : md.in_1;
        div_zero = op_is_div(md.op) & (md.in_1 == '0);
        div_ovf  = (md.op inside {MdDiv, MdRem}) & (md.in_0 == {1'b1, {(XLEN-1){1'b0}}})
                   & (md.in_1 == '1);
        if (div_zero) begin
            fast_res = op_is_rem(md.op) ? md.in_0 : '1;
        end else begin
            fast_res = op_is_rem(md.op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    logic [XLEN:0]         mul_sum, rem_sh;
    logic [XLEN-1:0]       diff, quo, rem, res;
    logic [2*XLEN-1:0]     acc_next, prod;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
        // Partial remainder keeps its carry-out so the compare sees the full 33-bit value.
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = rem_sh[XLEN-1:0] - d_q;
        if (op_is_div(op_q)) begin
            if (rem_sh >= {1'b0, d_q}) begin
                acc_next = {diff, acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_q ? -acc_next : acc_next;
        quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = nega_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        unique case (op_q)
            MdMul:                   res = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: res = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:           res = quo;
            default:                 res = rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            op_q    <= MdMul;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            d_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else if (md.flush) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                MdIdle: begin
                    done_q <= 1'b0;
                    if (md.start) begin
                        op_q   <= md.op;
                        neg_q  <= neg_a ^ neg_b;
                        nega_q <= neg_a;
                        d_q    <= op_is_div(md.op) ? b_mag : a_mag;
                        acc_q  <= {{XLEN{1'b0}}, op_is_div(md.op) ? a_mag : b_mag};
                        cnt_q  <= '0;
                        if (div_zero || div_ovf) begin
                            state_q <= MdDone;
                            done_q  <= 1'b1;
                            out_q   <= fast_res;
                        end else begin
                            state_q <= MdCalc;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                MdCalc: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_q <= MdDone;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= res;
                    end
                end
                MdDone: begin
                    // The finished instruction is still on the inputs; never restart here.
                    state_q <= MdIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= MdIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md.stall_req = ~reset_i & (((state_q == MdIdle) & md.start & ~md.flush)
                                      | (state_q == MdCalc));
    assign md.busy      = busy_q;
    assign md.done      = done_q;
    assign md.out       = out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corner cases plus random ops
// against an arithmetic reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [31:0] last_out = '0;
    logic done_prev = 1'b0;

    ex_muldiv_if dut_if();

    ex_muldiv #(.XLEN(32)) u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .md      (dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dut_if.done === 1'b1) begin
            checks++;
            if (done_prev === 1'b1) begin
                errors++;
                $display("FAIL done_pulse: done high two cycles running at cycle %0d, want 1 cycle",
                         cyc);
            end
        end
        done_prev = dut_if.done;
    end

    function automatic logic [31:0] ref_md(md_op_e op, logic [31:0] a, logic [31:0] b);
        int ia, ib, q;
        longint sa, sb, ub, p;
        longint unsigned ua, uub, pu;
        ia = a; ib = b;
        sa = longint'(ia); sb = longint'(ib);
        ub = longint'({32'b0, b});
        ua = {32'b0, a}; uub = {32'b0, b};
        case (op)
            MdMul:    begin p = sa * sb; return p[31:0]; end
            MdMulh:   begin p = sa * sb; return p[63:32]; end
            MdMulhsu: begin p = sa * ub; return p[63:32]; end
            MdMulhu:  begin pu = ua * uub; return pu[63:32]; end
            MdDiv: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib; return q;
            end
            MdRem: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib; return q;
            end
            MdDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Entered and left #1 after a rising edge; start is left high for the caller.
    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output int done_cyc);
        int lat;
        bit seen, stall_ok;
        lat = (((op inside {MdDiv, MdDivu, MdRem, MdRemu}) && b == 0) ||
               ((op inside {MdDiv, MdRem}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
              ? 1 : 33;
        dut_if.start = 1'b1;
        dut_if.op    = op;
        dut_if.in_0  = a;
        dut_if.in_1  = b;
        seen = 0; stall_ok = 1; done_cyc = -1;
        for (int c = 0; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (dut_if.stall_req !== 1'b1) begin
                    errors++;
                    $display("FAIL %s start_stall: stall_req=%b want 1", op.name(),
                             dut_if.stall_req);
                end
            end
            if (c == 1) begin
                checks++;
                if (dut_if.busy !== (lat == 33)) begin
                    errors++;
                    $display("FAIL %s busy: busy=%b want %b", op.name(), dut_if.busy, lat == 33);
                end
            end
            if (dut_if.done === 1'b1) begin
                seen = 1;
                done_cyc = cyc;
                checks += 3;
                if (c != lat) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want %0d", op.name(), c, lat);
                end
                if (dut_if.out !== exp) begin
                    errors++;
                    $display("FAIL %s result a=%h b=%h: out=%h want %h", op.name(), a, b,
                             dut_if.out, exp);
                end
                if (dut_if.stall_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_stall: stall_req=%b want 0", op.name(),
                             dut_if.stall_req);
                end
            end else if (dut_if.stall_req !== 1'b1) begin
                stall_ok = 0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done=0 after 40 cycles want done", op.name());
        end else begin
            last_out = exp;
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL %s stall_hold: stall_req dropped before done, want held", op.name());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dut_if.start = 1'b0; dut_if.flush = 1'b0;
        dut_if.op = MdMul; dut_if.in_0 = '0; dut_if.in_1 = '0;
        repeat (3) @(posedge clk);
        dut_if.start = 1'b1;
        @(negedge clk);
        checks += 4;
        if (dut_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b want 0", dut_if.busy); end
        if (dut_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: %b want 0", dut_if.done); end
        if (dut_if.out !== 32'h0) begin errors++; $display("FAIL reset_out: %h want 0", dut_if.out); end
        if (dut_if.stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_stall: %b want 0", dut_if.stall_req);
        end
        @(posedge clk); #1;
        reset = 1'b0; dut_if.start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int dc;
        do_op(MdMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, dc);
        do_op(MdMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, dc);
        do_op(MdMulh,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         dc);
        dut_if.start = 1'b0; @(posedge clk); #1;
        do_op(MdMulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, dc);
        do_op(MdDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, dc);
        do_op(MdRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, dc);
        do_op(MdDivu,   32'd100,        32'd7,         32'd14,        dc);
        do_op(MdRemu,   32'd100,        32'd7,         32'd2,         dc);
        do_op(MdDiv,    32'd5,          32'd0,         32'hFFFF_FFFF, dc);
        do_op(MdRem,    32'd5,          32'd0,         32'd5,         dc);
        do_op(MdDiv,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, dc);
        do_op(MdRem,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         dc);
        do_op(MdDivu,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         dc);
        dut_if.start = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int dc;
        bit done_seen = 0;
        dut_if.start = 1'b1; dut_if.op = MdDivu; dut_if.in_0 = 32'd1000; dut_if.in_1 = 32'd3;
        repeat (10) begin
            @(negedge clk); if (dut_if.done === 1'b1) done_seen = 1;
            @(posedge clk); #1;
        end
        dut_if.flush = 1'b1;
        @(negedge clk); if (dut_if.done === 1'b1) done_seen = 1;
        @(posedge clk); #1;
        dut_if.flush = 1'b0; dut_if.start = 1'b0;
        @(negedge clk);
        checks += 5;
        if (done_seen || dut_if.done !== 1'b0) begin
            errors++; $display("FAIL flush_done: done seen=%b now=%b want 0", done_seen, dut_if.done);
        end
        if (dut_if.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: %b want 0", dut_if.busy); end
        if (dut_if.stall_req !== 1'b0) begin
            errors++; $display("FAIL flush_stall: %b want 0", dut_if.stall_req);
        end
        if (dut_if.out !== last_out) begin
            errors++; $display("FAIL flush_out_hold: %h want %h", dut_if.out, last_out);
        end
        @(posedge clk); #1;
        // A start presented together with flush in IDLE must be dropped.
        dut_if.start = 1'b1; dut_if.flush = 1'b1; dut_if.op = MdMul;
        dut_if.in_0 = 32'd9; dut_if.in_1 = 32'd9;
        @(negedge clk);
        if (dut_if.stall_req !== 1'b0) begin
            errors++; $display("FAIL flush_start_stall: %b want 0", dut_if.stall_req);
        end
        @(posedge clk); #1;
        dut_if.start = 1'b0; dut_if.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_if.busy !== 1'b0 || dut_if.done !== 1'b0) begin
            errors++; $display("FAIL flush_start_ignored: busy=%b done=%b want 0 0",
                               dut_if.busy, dut_if.done);
        end
        @(posedge clk); #1;
        do_op(MdMul, 32'd12, 32'd11, 32'd132, dc);
        dut_if.start = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        do_op(MdMul, 32'd3, 32'd5, 32'd15, c1);
        do_op(MdMul, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, c2);
        dut_if.start = 1'b0;
        checks++;
        if (c2 - c1 != 34) begin
            errors++; $display("FAIL back_to_back_gap: %0d cycles want 34", c2 - c1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        dut_if.start = 1'b1; dut_if.op = MdMulhu;
        dut_if.in_0 = 32'hDEAD_BEEF; dut_if.in_1 = 32'h1234_5678;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_if.stall_req !== 1'b0) begin
            errors++; $display("FAIL midreset_stall: %b want 0", dut_if.stall_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 3;
        if (dut_if.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: %b want 0", dut_if.busy); end
        if (dut_if.done !== 1'b0) begin errors++; $display("FAIL midreset_done: %b want 0", dut_if.done); end
        if (dut_if.out !== 32'h0) begin errors++; $display("FAIL midreset_out: %h want 0", dut_if.out); end
        @(posedge clk); #1;
        reset = 1'b0; dut_if.start = 1'b0;
        @(posedge clk); #1;
        last_out = '0;
    endtask

    task automatic test_random();
        int dc;
        md_op_e op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = md_op_e'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = b >> $urandom_range(8, 31);
                default: ;
            endcase
            do_op(op, a, b, ref_md(op, a, b), dc);
            if ($urandom_range(0, 1) == 1) begin
                dut_if.start = 1'b0; @(posedge clk); #1;
            end
        end
        dut_if.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, beside the single-cycle ALU. It executes RV32M operations over multiple cycles and stalls the pipeline through the existing `stall` path until the result is ready. On completion it presents the result for exactly one cycle, timed so that the EX/MEM register captures it on the same edge the stall releases. A flush or interrupt abort cancels it cleanly.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk`, input, 1: single clock.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: an M-extension instruction is valid in ID/EX. Held high by the pipeline while stalled.
- `op`, input, 3: operation code (`MD_OP_*`).
- `in_0`, input, 32: rs1 operand (dividend or multiplicand).
- `in_1`, input, 32: rs2 operand (divisor or multiplier).
- `flush`, input, 1: abort. The pipeline ORs `int_detect` into this signal.
- `stall_req`, output, 1: combinational request to hold the IF, ID and EX stages.
- `busy`, output, 1: registered; high in CALC.
- `done`, output, 1: registered; high for one cycle in DONE.
- `out`, output, 32: registered result, valid while `done` is high.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `start & ~flush` latches operands, sign flags and op, and sets cnt = 0.
  - The next state is normally CALC.
  - The next state is DONE (fast path) when either:
    - a divide/remainder op has `in_1 == 0`, or
    - DIV/REM has `in_0 == 32'h8000_0000` and `in_1 == 32'hFFFF_FFFF`.
- CALC: one radix-2 step per cycle; cnt runs 0..31. When cnt == 31 the next state is DONE.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing a 32-bit quotient and remainder.
- DONE: `done` = 1 and `out` holds the result. The next state is always IDLE. `start` is ignored in DONE, because the completed instruction is still present on the inputs.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats `in_0` as signed and `in_1` as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Result sign fix is applied on the DONE-entry edge:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- Divide by zero: quotient = 32'hFFFF_FFFF; remainder = `in_0`.
- Signed overflow: quotient = 32'h8000_0000; remainder = 0.
- `stall_req` = `(IDLE & start & ~flush) | CALC`. It is 0 in DONE, so the pipeline advances on the DONE edge.
- `flush` in any state: the next state is IDLE, cnt clears, and `done` stays 0 the next cycle. `out` retains its previous value.
- `flush` together with `start` in IDLE: the start is not accepted.
- `reset`: state = IDLE, `busy` = 0, `done` = 0, `out` = 0, cnt = 0. `stall_req` is forced to 0 during reset.
- `start` while in CALC is ignored.
- The ALU and EX/MEM register are unchanged. The EX stage muxes `out` onto the ALU result path when `done` is high.

## Timing
- Cycle 0: `start` is sampled in IDLE and `stall_req` = 1.
- Normal path: CALC occupies cycles 1–32; DONE is cycle 33, with `done` = 1 and `stall_req` = 0. The EX/MEM register captures the result at the end of cycle 33. Total latency is 33 cycles after the start cycle, so the instruction occupies EX for 34 cycles.
- Fast path: DONE is cycle 1.
- Back-to-back M instructions: the second one arrives in EX in cycle 34. IDLE accepts it with no bubble.
- `busy` is exactly 1 in CALC.
- `done` is never high for two consecutive cycles.

## Structure
- `MD_OP_*` go in the shared header `head/cpu_head.v` as defines:
  - MUL = 0, MULH = 1, MULHSU = 2, MULHU = 3
  - DIV = 4, DIVU = 5, REM = 6, REMU = 7
- State encodings `MD_IDLE`, `MD_CALC` and `MD_DONE` also go in `head/cpu_head.v`.
- The block is a single module. The FSM and the 64-bit shift datapath are kept inline.
- An optional combinational sub-module `md_sign_fix` performs operand absolute value and result negation.

## Test plan
- MUL 7 × −3 → `out` = 32'hFFFF_FFEB at cycle 33; `stall_req` is high for cycles 0–32 and low at 33.
- MULHU 32'hFFFF_FFFF × 32'hFFFF_FFFF → `out` = 32'hFFFF_FFFE. MULH with the same operands → 0.
- DIV −7 / 2 → −3 (32'hFFFF_FFFD); REM −7 / 2 → −1. DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 32'hFFFF_FFFF and REM 5 / 0 → 5, both in DONE at cycle 1. DIV 32'h8000_0000 / −1 → 32'h8000_0000 at cycle 1.
- `flush` asserted at cycle 10 of a DIVU → IDLE next cycle; `done` is never asserted; `stall_req` drops; a new `start` is accepted in the following cycle.
- `reset` asserted mid-CALC → all outputs are 0 on the next edge. Two back-to-back MULs → two single-cycle `done` pulses 34 cycles apart.
